// File: rtl/gate_controller.sv
// Entry/exit gate sequencer: conditions raw lane sensors, classifies cars by tag
// and emits one car_entered/car_exited pulse per car that physically passes.

module gate_controller_debounce #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_filt
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_filt;
  logic [CW-1:0] r_cnt;

  // Filtered value flips once the synchronised input has differed for DEBOUNCE cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
        r_cnt  <= '0;
        r_filt <= r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

module gate_controller #(
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned TAG_TIMEOUT  = 16,
  parameter int unsigned GATE_TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic ent_sensor,
  input  logic ent_pass,
  input  logic ent_tag_valid,
  input  logic ent_tag_uni,
  input  logic ext_sensor,
  input  logic ext_pass,
  input  logic ext_tag_valid,
  input  logic ext_tag_uni,
  input  logic is_uni_vacated_space,
  input  logic is_vacated_space,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited,
  output logic ent_gate_open,
  output logic ext_gate_open,
  output logic ent_reject
);

  localparam int unsigned TMAX = (TAG_TIMEOUT > GATE_TIMEOUT) ? TAG_TIMEOUT : GATE_TIMEOUT;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] TAG_LAST  = TW'(TAG_TIMEOUT - 1);
  localparam logic [TW-1:0] GATE_LAST = TW'(GATE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DECIDE,
    S_OPEN,
    S_REJECT,
    S_CLOSE
  } state_t;

  logic w_ent_sensor;
  logic w_ent_pass;
  logic w_ext_sensor;
  logic w_ext_pass;
  logic w_ent_pass_rise;
  logic w_ext_pass_rise;

  gate_controller_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_ent_sensor (
    .i_clk(clk), .i_rst_n(rst), .i_raw(ent_sensor), .o_filt(w_ent_sensor)
  );
  gate_controller_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_ent_pass (
    .i_clk(clk), .i_rst_n(rst), .i_raw(ent_pass), .o_filt(w_ent_pass)
  );
  gate_controller_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_ext_sensor (
    .i_clk(clk), .i_rst_n(rst), .i_raw(ext_sensor), .o_filt(w_ext_sensor)
  );
  gate_controller_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_ext_pass (
    .i_clk(clk), .i_rst_n(rst), .i_raw(ext_pass), .o_filt(w_ext_pass)
  );

  state_t        r_ent_st;
  state_t        r_ext_st;
  logic [TW-1:0] r_ent_tmr;
  logic [TW-1:0] r_ext_tmr;
  logic          r_ent_cls;
  logic          r_ext_cls;
  logic          r_ent_pass_d;
  logic          r_ext_pass_d;
  logic          r_car_entered;
  logic          r_uni_entered;
  logic          r_car_exited;
  logic          r_uni_exited;
  logic          r_ent_open;
  logic          r_ext_open;
  logic          r_ent_reject;

  // Rise is high only in the first cycle the filtered pass reads 1.
  assign w_ent_pass_rise = w_ent_pass & ~r_ent_pass_d;
  assign w_ext_pass_rise = w_ext_pass & ~r_ext_pass_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ent_st      <= S_IDLE;
      r_ent_tmr     <= '0;
      r_ent_cls     <= 1'b0;
      r_ent_pass_d  <= 1'b0;
      r_car_entered <= 1'b0;
      r_uni_entered <= 1'b0;
      r_ent_open    <= 1'b0;
      r_ent_reject  <= 1'b0;
    end else begin
      r_ent_pass_d  <= w_ent_pass;
      r_car_entered <= 1'b0;
      r_uni_entered <= 1'b0;
      case (r_ent_st)
        S_IDLE: begin
          if (w_ent_sensor) begin
            r_ent_st  <= S_READ;
            r_ent_tmr <= '0;
            r_ent_cls <= 1'b0;
          end
        end
        S_READ: begin
          if (!w_ent_sensor) begin
            r_ent_st <= S_IDLE;
          end else if (ent_tag_valid) begin
            r_ent_cls <= ent_tag_uni;
            r_ent_st  <= S_DECIDE;
          end else if (r_ent_tmr == TAG_LAST) begin
            r_ent_st <= S_DECIDE;
          end else begin
            r_ent_tmr <= r_ent_tmr + 1'b1;
          end
        end
        S_DECIDE: begin
          if (r_ent_cls ? is_uni_vacated_space : is_vacated_space) begin
            r_ent_st   <= S_OPEN;
            r_ent_open <= 1'b1;
            r_ent_tmr  <= '0;
          end else begin
            r_ent_st     <= S_REJECT;
            r_ent_reject <= 1'b1;
          end
        end
        S_OPEN: begin
          // A pass in the expiry cycle still counts as a pass.
          if (w_ent_pass_rise) begin
            r_car_entered <= 1'b1;
            r_uni_entered <= r_ent_cls;
            r_ent_open    <= 1'b0;
            r_ent_st      <= S_CLOSE;
          end else if (r_ent_tmr == GATE_LAST) begin
            r_ent_open <= 1'b0;
            r_ent_st   <= S_CLOSE;
          end else begin
            r_ent_tmr <= r_ent_tmr + 1'b1;
          end
        end
        S_REJECT: begin
          if (!w_ent_sensor) begin
            r_ent_reject <= 1'b0;
            r_ent_st     <= S_IDLE;
          end
        end
        S_CLOSE: begin
          if (!w_ent_sensor && !w_ent_pass) r_ent_st <= S_IDLE;
        end
        default: begin
          r_ent_st     <= S_IDLE;
          r_ent_open   <= 1'b0;
          r_ent_reject <= 1'b0;
        end
      endcase
    end
  end

  // Exits are never refused, so a classified car goes straight to OPEN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ext_st     <= S_IDLE;
      r_ext_tmr    <= '0;
      r_ext_cls    <= 1'b0;
      r_ext_pass_d <= 1'b0;
      r_car_exited <= 1'b0;
      r_uni_exited <= 1'b0;
      r_ext_open   <= 1'b0;
    end else begin
      r_ext_pass_d <= w_ext_pass;
      r_car_exited <= 1'b0;
      r_uni_exited <= 1'b0;
      case (r_ext_st)
        S_IDLE: begin
          if (w_ext_sensor) begin
            r_ext_st  <= S_READ;
            r_ext_tmr <= '0;
            r_ext_cls <= 1'b0;
          end
        end
        S_READ: begin
          if (!w_ext_sensor) begin
            r_ext_st <= S_IDLE;
          end else if (ext_tag_valid || (r_ext_tmr == TAG_LAST)) begin
            r_ext_cls  <= ext_tag_valid & ext_tag_uni;
            r_ext_st   <= S_OPEN;
            r_ext_open <= 1'b1;
            r_ext_tmr  <= '0;
          end else begin
            r_ext_tmr <= r_ext_tmr + 1'b1;
          end
        end
        S_OPEN: begin
          if (w_ext_pass_rise) begin
            r_car_exited <= 1'b1;
            r_uni_exited <= r_ext_cls;
            r_ext_open   <= 1'b0;
            r_ext_st     <= S_CLOSE;
          end else if (r_ext_tmr == GATE_LAST) begin
            r_ext_open <= 1'b0;
            r_ext_st   <= S_CLOSE;
          end else begin
            r_ext_tmr <= r_ext_tmr + 1'b1;
          end
        end
        S_CLOSE: begin
          if (!w_ext_sensor && !w_ext_pass) r_ext_st <= S_IDLE;
        end
        default: begin
          r_ext_st   <= S_IDLE;
          r_ext_open <= 1'b0;
        end
      endcase
    end
  end

  assign car_entered        = r_car_entered;
  assign is_uni_car_entered = r_uni_entered;
  assign car_exited         = r_car_exited;
  assign is_uni_car_exited  = r_uni_exited;
  assign ent_gate_open      = r_ent_open;
  assign ext_gate_open      = r_ext_open;
  assign ent_reject         = r_ent_reject;

endmodule

// File: tb/tb_gate_controller.sv
// Self-checking bench for gate_controller: table vectors, hand-built corner
// sequences and randomized cars checked against outcome rules per car.

module tb_gate_controller;

  localparam int GATE_TO = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ent_sensor = 1'b0, ent_pass = 1'b0, ent_tag_valid = 1'b0, ent_tag_uni = 1'b0;
  logic ext_sensor = 1'b0, ext_pass = 1'b0, ext_tag_valid = 1'b0, ext_tag_uni = 1'b0;
  logic is_uni_vacated_space = 1'b0, is_vacated_space = 1'b0;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic ent_gate_open, ext_gate_open, ent_reject;

  always #5 clk = ~clk;

  gate_controller #(.DEBOUNCE(4), .TAG_TIMEOUT(16), .GATE_TIMEOUT(GATE_TO)) dut (
    .clk(clk), .rst(rst),
    .ent_sensor(ent_sensor), .ent_pass(ent_pass),
    .ent_tag_valid(ent_tag_valid), .ent_tag_uni(ent_tag_uni),
    .ext_sensor(ext_sensor), .ext_pass(ext_pass),
    .ext_tag_valid(ext_tag_valid), .ext_tag_uni(ext_tag_uni),
    .is_uni_vacated_space(is_uni_vacated_space), .is_vacated_space(is_vacated_space),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .ent_gate_open(ent_gate_open), .ext_gate_open(ext_gate_open),
    .ent_reject(ent_reject)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitor: pulse counts, pulse class, open/reject cycles, rule violations.
  int cyc = 0, viol = 0;
  int ent_pulses = 0, ext_pulses = 0, ent_open_cyc = 0, ext_open_cyc = 0, rej_cyc = 0;
  int ent_last_uni = -1, ext_last_uni = -1, ent_pulse_cyc = -1, ext_pulse_cyc = -2;
  logic prev_ent_open = 1'b0, prev_ext_open = 1'b0, prev_ce = 1'b0, prev_cx = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (car_entered) begin
      ent_pulses++;
      ent_last_uni  = is_uni_car_entered;
      ent_pulse_cyc = cyc;
      if (!prev_ent_open || prev_ce) viol++;
    end
    if (car_exited) begin
      ext_pulses++;
      ext_last_uni  = is_uni_car_exited;
      ext_pulse_cyc = cyc;
      if (!prev_ext_open || prev_cx) viol++;
    end
    if (is_uni_car_entered && !car_entered) viol++;
    if (is_uni_car_exited && !car_exited) viol++;
    if (ent_gate_open && ent_reject) viol++;
    if (ent_gate_open) ent_open_cyc++;
    if (ext_gate_open) ext_open_cyc++;
    if (ent_reject) rej_cyc++;
    prev_ent_open = ent_gate_open;
    prev_ext_open = ext_gate_open;
    prev_ce = car_entered;
    prev_cx = car_exited;
  end

  // Outcome rules per car: class from tag (none => free); entry granted iff the
  // space flag of that class is set; one pulse iff granted and the car passes.
  function automatic bit model_grant(input int tag_mode, input bit usp, input bit fsp);
    return (tag_mode == 2) ? usp : fsp;
  endfunction

  // tag_mode: 0 = no tag (timeout), 1 = free tag, 2 = uni tag.
  task automatic ent_car(input int tag_mode, input int tag_dly, input bit usp, input bit fsp,
                         input bit do_pass, input int pass_dly, input bit exp_open,
                         input bit exp_uni, input string nm);
    int p0, o0;
    bit opened, rejected, closed, cleared;
    p0 = ent_pulses; o0 = ent_open_cyc;
    opened = 0; rejected = 0; closed = 0; cleared = 0;
    is_uni_vacated_space = usp; is_vacated_space = fsp;
    ent_sensor = 1'b1;
    if (tag_mode != 0) begin
      cycles(7 + tag_dly);
      ent_tag_valid = 1'b1; ent_tag_uni = (tag_mode == 2);
      cycles(1);
      ent_tag_valid = 1'b0; ent_tag_uni = 1'b0;
    end
    for (int i = 0; i < 60 && !opened && !rejected; i++) begin
      @(negedge clk);
      opened = ent_gate_open; rejected = ent_reject;
    end
    check({nm, ".open"}, opened, exp_open);
    check({nm, ".reject"}, rejected, !exp_open);
    if (opened) begin
      // Space flags dropping after the decision must not affect the open gate.
      is_uni_vacated_space = 1'b0; is_vacated_space = 1'b0;
      if (do_pass) begin
        cycles(pass_dly);
        ent_pass = 1'b1;
      end
      for (int i = 0; i < (do_pass ? 40 : GATE_TO + 40); i++) begin
        @(negedge clk);
        if (!ent_gate_open) begin closed = 1; break; end
      end
      check({nm, ".closed"}, closed, 1);
    end
    ent_sensor = 1'b0;
    if (rejected) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!ent_reject) begin cleared = 1; break; end
      end
      check({nm, ".reject_clears"}, cleared, 1);
    end
    ent_pass = 1'b0;
    cycles(12);
    check({nm, ".pulses"}, ent_pulses - p0, exp_open && do_pass);
    if (exp_open && do_pass) check({nm, ".class"}, ent_last_uni, exp_uni);
    if (exp_open && !do_pass) check({nm, ".open_len"}, ent_open_cyc - o0, GATE_TO);
    if (!exp_open) check({nm, ".never_open"}, ent_open_cyc - o0, 0);
  endtask

  task automatic ext_car(input int tag_mode, input int tag_dly, input bit do_pass,
                         input int pass_dly, input bit exp_uni, input string nm);
    int p0, o0;
    bit opened, closed;
    p0 = ext_pulses; o0 = ext_open_cyc;
    opened = 0; closed = 0;
    ext_sensor = 1'b1;
    if (tag_mode != 0) begin
      cycles(7 + tag_dly);
      ext_tag_valid = 1'b1; ext_tag_uni = (tag_mode == 2);
      cycles(1);
      ext_tag_valid = 1'b0; ext_tag_uni = 1'b0;
    end
    for (int i = 0; i < 60 && !opened; i++) begin
      @(negedge clk);
      opened = ext_gate_open;
    end
    check({nm, ".open"}, opened, 1);
    if (do_pass) begin
      cycles(pass_dly);
      ext_pass = 1'b1;
    end
    for (int i = 0; i < (do_pass ? 40 : GATE_TO + 40); i++) begin
      @(negedge clk);
      if (!ext_gate_open) begin closed = 1; break; end
    end
    check({nm, ".closed"}, closed, 1);
    ext_sensor = 1'b0; ext_pass = 1'b0;
    cycles(12);
    check({nm, ".pulses"}, ext_pulses - p0, do_pass);
    if (do_pass) check({nm, ".class"}, ext_last_uni, exp_uni);
    else check({nm, ".open_len"}, ext_open_cyc - o0, GATE_TO);
  endtask

  // Opens an entry gate (free car, no tag) and raises pass 'off' cycles after the gate opens.
  task automatic pass_at(input int off, output int pulses, output int open_len, output bit opened);
    int p0, o0;
    p0 = ent_pulses; o0 = ent_open_cyc; opened = 0;
    is_uni_vacated_space = 1'b0; is_vacated_space = 1'b1;
    ent_sensor = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ent_gate_open) begin opened = 1; break; end
    end
    repeat (off) @(posedge clk);
    #1 ent_pass = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ent_gate_open) break;
    end
    ent_pass = 1'b0; ent_sensor = 1'b0;
    cycles(12);
    pulses = ent_pulses - p0; open_len = ent_open_cyc - o0;
  endtask

  typedef struct {
    int tag_mode;
    bit usp;
    bit fsp;
    bit do_pass;
    bit exp_open;
    bit exp_uni;
  } ent_vec_t;

  typedef struct {
    int tag_mode;
    bit do_pass;
    bit exp_uni;
  } ext_vec_t;

  ent_vec_t ent_vecs[7];
  ext_vec_t ext_vecs[3];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pl, ol, p0, o0, x0, tm, td, pd, xtm, xtd, xpd;
    bit op, u, f, dp, xdp, ok;

    ent_vecs[0] = '{2, 1, 0, 1, 1, 1};  // uni tag, uni space free
    ent_vecs[1] = '{0, 1, 0, 1, 0, 0};  // no tag, lot full for free cars
    ent_vecs[2] = '{1, 0, 1, 1, 1, 0};  // free tag, free space
    ent_vecs[3] = '{2, 0, 1, 1, 0, 0};  // uni tag ignores free flag
    ent_vecs[4] = '{0, 0, 1, 1, 1, 0};  // timeout classified free
    ent_vecs[5] = '{2, 1, 1, 0, 1, 1};  // granted, never passes
    ent_vecs[6] = '{1, 1, 0, 1, 0, 0};  // free tag ignores uni flag
    ext_vecs[0] = '{2, 1, 1};
    ext_vecs[1] = '{0, 1, 0};
    ext_vecs[2] = '{1, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
                            ent_gate_open, ext_gate_open, ent_reject}, 0);
    rst = 1'b1;
    cycles(2);

    // 3-cycle sensor glitch must not start a transaction.
    o0 = ent_open_cyc; x0 = rej_cyc;
    is_uni_vacated_space = 1'b1; is_vacated_space = 1'b1;
    ent_sensor = 1'b1;
    cycles(3);
    ent_sensor = 1'b0;
    cycles(40);
    check("sensor_glitch3.no_activity", (ent_open_cyc - o0) + (rej_cyc - x0), 0);

    // Held sensor: no tag, timeout, free space -> open; then pass glitches.
    ent_sensor = 1'b1;
    op = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ent_gate_open) begin op = 1; break; end
    end
    check("sensor_held.open", op, 1);
    cycles(1);
    p0 = ent_pulses;
    ent_pass = 1'b1; cycles(2); ent_pass = 1'b0; cycles(10);
    ent_pass = 1'b1; cycles(3); ent_pass = 1'b0; cycles(10);
    check("pass_glitch.no_pulse", ent_pulses - p0, 0);
    check("pass_glitch.still_open", ent_gate_open, 1);
    ent_pass = 1'b1; cycles(4); ent_pass = 1'b0; cycles(10);
    check("pass4.pulse", ent_pulses - p0, 1);
    check("pass4.class", ent_last_uni, 0);
    check("pass4.closed", ent_gate_open, 0);
    ent_sensor = 1'b0;
    cycles(12);

    foreach (ent_vecs[i])
      ent_car(ent_vecs[i].tag_mode, 3, ent_vecs[i].usp, ent_vecs[i].fsp, ent_vecs[i].do_pass, 2,
              ent_vecs[i].exp_open, ent_vecs[i].exp_uni, $sformatf("ent_vec%0d", i));
    foreach (ext_vecs[i])
      ext_car(ext_vecs[i].tag_mode, 4, ext_vecs[i].do_pass, 1, ext_vecs[i].exp_uni,
              $sformatf("ext_vec%0d", i));

    // Pass edge landing on the gate-timer expiry cycle wins; one cycle later it is ignored.
    pass_at(GATE_TO - 7, pl, ol, op);
    check("expiry_pass.opened", op, 1);
    check("expiry_pass.pulse", pl, 1);
    check("expiry_pass.open_len", ol, GATE_TO);
    pass_at(GATE_TO - 6, pl, ol, op);
    check("late_pass.opened", op, 1);
    check("late_pass.no_pulse", pl, 0);
    check("late_pass.open_len", ol, GATE_TO);

    // Concurrent lanes: free entry and uni exit with coinciding pass edges.
    p0 = ent_pulses; x0 = ext_pulses;
    is_uni_vacated_space = 1'b0; is_vacated_space = 1'b1;
    ent_sensor = 1'b1; ext_sensor = 1'b1;
    cycles(9);
    ent_tag_valid = 1'b1; ent_tag_uni = 1'b0; ext_tag_valid = 1'b1; ext_tag_uni = 1'b1;
    cycles(1);
    ent_tag_valid = 1'b0; ext_tag_valid = 1'b0; ext_tag_uni = 1'b0;
    op = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ent_gate_open && ext_gate_open) begin op = 1; break; end
    end
    check("concurrent.both_open", op, 1);
    ent_pass = 1'b1; ext_pass = 1'b1;
    cycles(15);
    check("concurrent.ent_pulse", ent_pulses - p0, 1);
    check("concurrent.ext_pulse", ext_pulses - x0, 1);
    check("concurrent.same_cycle", ent_pulse_cyc - ext_pulse_cyc, 0);
    check("concurrent.ent_class", ent_last_uni, 0);
    check("concurrent.ext_class", ext_last_uni, 1);
    ent_pass = 1'b0; ext_pass = 1'b0; ent_sensor = 1'b0; ext_sensor = 1'b0;
    cycles(12);

    // Reset while the entry gate is open.
    p0 = ent_pulses; o0 = ent_open_cyc;
    is_uni_vacated_space = 1'b1; is_vacated_space = 1'b1;
    ent_sensor = 1'b1;
    op = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ent_gate_open) begin op = 1; break; end
    end
    check("rst_open.opened", op, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("rst_open.gate_closed", ent_gate_open, 0);
    ent_sensor = 1'b0;
    cycles(3);
    rst = 1'b1;
    o0 = ent_open_cyc;
    cycles(20);
    check("rst_open.no_pulse", ent_pulses - p0, 0);
    check("rst_open.stays_idle", (ent_open_cyc - o0) + ent_reject, 0);

    // Randomized cars on both lanes at once.
    for (int n = 0; n < 14; n++) begin
      tm = $urandom_range(0, 2); td = $urandom_range(1, 10);
      u = $urandom_range(0, 1); f = $urandom_range(0, 1);
      dp = ($urandom_range(0, 3) != 0); pd = $urandom_range(0, 20);
      xtm = $urandom_range(0, 2); xtd = $urandom_range(1, 10);
      xdp = ($urandom_range(0, 3) != 0); xpd = $urandom_range(0, 20);
      ok = model_grant(tm, u, f);
      fork
        ent_car(tm, td, u, f, dp, pd, ok, (tm == 2), $sformatf("rnd%0d.ent", n));
        ext_car(xtm, xtd, xdp, xpd, (xtm == 2), $sformatf("rnd%0d.ext", n));
      join
    end

    check("pulse_rules", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
